// File: rtl/shake_arbiter_if.sv
// Requester-side and sponge-side signals of the shared SHAKE256 arbiter.
// slave = arbiter view, master = requesters plus sponge.
interface shake_arbiter_if #(
    parameter int NUM_REQ       = 3,
    parameter int DATA_IN_BITS  = 64,
    parameter int DATA_OUT_BITS = 64
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LEN_W = $clog2(DATA_IN_BITS) + 1;

    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0]              gnt;
    logic [IDX_W-1:0]                owner;
    logic                            busy;

    logic [NUM_REQ*DATA_IN_BITS-1:0] rq_data_in;
    logic [NUM_REQ-1:0]              rq_in_valid;
    logic [NUM_REQ-1:0]              rq_in_last;
    logic [NUM_REQ-1:0]              rq_out_ready;
    logic [NUM_REQ*LEN_W-1:0]        rq_last_len;
    logic [NUM_REQ-1:0]              rq_in_ready;
    logic [NUM_REQ-1:0]              rq_out_valid;
    logic [DATA_OUT_BITS-1:0]        rq_data_out;

    logic                            sp_clr;
    logic [DATA_IN_BITS-1:0]         sp_data_in;
    logic                            sp_in_valid;
    logic                            sp_in_last;
    logic                            sp_out_ready;
    logic [LEN_W-1:0]                sp_last_len;
    logic [DATA_OUT_BITS-1:0]        sp_data_out;
    logic                            sp_out_valid;
    logic                            sp_in_ready;

    modport slave (
        input  req, rq_data_in, rq_in_valid, rq_in_last, rq_out_ready, rq_last_len,
        input  sp_data_out, sp_out_valid, sp_in_ready,
        output gnt, owner, busy, rq_in_ready, rq_out_valid, rq_data_out,
        output sp_clr, sp_data_in, sp_in_valid, sp_in_last, sp_out_ready, sp_last_len
    );

    modport master (
        output req, rq_data_in, rq_in_valid, rq_in_last, rq_out_ready, rq_last_len,
        output sp_data_out, sp_out_valid, sp_in_ready,
        input  gnt, owner, busy, rq_in_ready, rq_out_valid, rq_data_out,
        input  sp_clr, sp_data_in, sp_in_valid, sp_in_last, sp_out_ready, sp_last_len
    );
endinterface

// File: rtl/shake_arbiter.sv
// Round-robin owner of one shared SHAKE256 sponge; each grant is preceded by a
// sponge clear so every transaction starts from a fresh Keccak state.
module shake_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int DATA_IN_BITS  = 64,
    parameter int DATA_OUT_BITS = 64,
    parameter int CLR_CYCLES    = 1
) (
    input  logic           clk,
    input  logic           rst,
    shake_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LEN_W = $clog2(DATA_IN_BITS) + 1;
    localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, GRANT} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   prio_q;
    logic [IDX_W-1:0]   owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               busy_q;
    logic               clr_q;

    logic [IDX_W-1:0]   win_d;
    logic [IDX_W-1:0]   idx;
    logic               found;
    logic               any_req;
    logic               owner_req;
    logic [NUM_REQ-1:0] sel;
    logic [DATA_OUT_BITS-1:0] sp_word;

    assign any_req   = |bus.req;
    assign owner_req = bus.req[owner_q];

    // First set request scanning upward from prio_q, wrapping at NUM_REQ.
    always_comb begin
        win_d = prio_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(prio_q) + k) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                win_d = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            prio_q  <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= CLEAR;
                        owner_q <= win_d;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        clr_q   <= 1'b1;
                    end
                end
                CLEAR: begin
                    // An abandoned clear leaves prio_q alone so the same requester keeps its turn.
                    if (!owner_req) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        clr_q   <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= GRANT;
                        clr_q   <= 1'b0;
                        gnt_q   <= NUM_REQ'(1) << owner_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        gnt_q   <= '0;
                        prio_q  <= (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    clr_q   <= 1'b0;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    // Routing is gated by the live req so a dropping requester is cut off in the same cycle.
    assign sel = gnt_q & bus.req;

    always_comb begin
        bus.sp_data_in   = '0;
        bus.sp_in_valid  = 1'b0;
        bus.sp_in_last   = 1'b0;
        bus.sp_out_ready = 1'b0;
        bus.sp_last_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel[i]) begin
                bus.sp_data_in   = bus.rq_data_in[i*DATA_IN_BITS +: DATA_IN_BITS];
                bus.sp_in_valid  = bus.rq_in_valid[i];
                bus.sp_in_last   = bus.rq_in_last[i];
                bus.sp_out_ready = bus.rq_out_ready[i];
                bus.sp_last_len  = bus.rq_last_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign bus.rq_in_ready  = sel & {NUM_REQ{bus.sp_in_ready}};
    assign bus.rq_out_valid = sel & {NUM_REQ{bus.sp_out_valid}};
    assign sp_word          = bus.sp_data_out;
    assign bus.rq_data_out  = sp_word;

    // The sponge is held in reset along with the arbiter itself.
    assign bus.sp_clr = ~rst | clr_q;
    assign bus.gnt    = gnt_q;
    assign bus.owner  = owner_q;
    assign bus.busy   = busy_q;

    a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt_q));
endmodule

// File: tb/tb_shake_arbiter.sv
// Directed bench for shake_arbiter with a toy sponge model and a grant/data scoreboard.
module tb_shake_arbiter;
    localparam int NR  = 3;
    localparam int LW  = 7;
    localparam int CLR = 1;
    localparam logic [63:0] KMIX = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] KSQZ = 64'hC2B2AE3D27D4EB4F;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [63:0]   dq[$];
    logic [NR-1:0] gq[$];

    shake_arbiter_if #(.NUM_REQ(NR), .DATA_IN_BITS(64), .DATA_OUT_BITS(64)) bus ();

    shake_arbiter #(
        .NUM_REQ(NR), .DATA_IN_BITS(64), .DATA_OUT_BITS(64), .CLR_CYCLES(CLR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] mix(input logic [63:0] s, input logic [63:0] d,
                                        input logic last, input logic [6:0] len);
        logic [63:0] r;
        r = {s[58:0], s[63:59]} ^ d ^ KMIX;
        if (last) r = r ^ {57'd0, len};
        return r;
    endfunction

    // Toy sponge: absorbs until in_last, then squeezes st ^ (n+1)*KSQZ.
    logic [63:0] sp_st;
    logic        sp_sq;
    logic [63:0] sp_cnt;
    always_ff @(posedge clk) begin
        if (bus.sp_clr) begin
            sp_st  <= '0;
            sp_sq  <= 1'b0;
            sp_cnt <= '0;
        end else begin
            if (bus.sp_in_valid && !sp_sq) begin
                sp_st <= mix(sp_st, bus.sp_data_in, bus.sp_in_last, bus.sp_last_len);
                if (bus.sp_in_last) sp_sq <= 1'b1;
            end
            if (sp_sq && bus.sp_out_ready) sp_cnt <= sp_cnt + 64'd1;
        end
    end
    assign bus.sp_in_ready  = !sp_sq;
    assign bus.sp_out_valid = sp_sq;
    assign bus.sp_data_out  = sp_st ^ ((sp_cnt + 64'd1) * KSQZ);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    // Monitor: grant order, clear-before-grant, one-hot, squeeze data.
    initial begin
        logic [NR-1:0] prev_gnt;
        int            clr_run;
        prev_gnt = '0;
        clr_run  = 0;
        forever begin
            @(negedge clk);
            chk("gnt_onehot", 64'($countones(bus.gnt) <= 1), 64'd1);
            if (bus.gnt != '0 && prev_gnt == '0) begin
                if (gq.size() == 0) chk("gnt_unexpected", 64'(bus.gnt), 64'd0);
                else                chk("gnt_order", 64'(bus.gnt), 64'(gq.pop_front()));
                chk("clr_before_gnt", 64'(clr_run), 64'(CLR));
            end
            if ((bus.rq_out_valid & bus.rq_out_ready) != '0) begin
                if (dq.size() == 0) chk("squeeze_unexpected", bus.rq_data_out, 64'd0);
                else                chk("squeeze_word", bus.rq_data_out, dq.pop_front());
            end
            clr_run  = bus.sp_clr ? clr_run + 1 : 0;
            prev_gnt = bus.gnt;
        end
    end

    task automatic iso_chk();
        chk("iso_in_ready2", 64'(bus.rq_in_ready[2]), 64'd0);
        chk("iso_out_valid2", 64'(bus.rq_out_valid[2]), 64'd0);
        chk("iso_sp_in_valid", 64'(bus.sp_in_valid), 64'(bus.rq_in_valid[1]));
        bus.rq_in_valid[2] = ~bus.rq_in_valid[2];
    endtask

    task automatic wait_gnt(input int i, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            ok = bus.gnt[i];
        end
        if (!ok) fail_now("gnt_wait");
        else     chk("owner", 64'(bus.owner), 64'(i));
    endtask

    task automatic absorb(input int i, input int nb, input logic [63:0] d, input bit iso,
                          output logic [63:0] st);
        bit ok;
        st = '0;
        for (int b = 0; b < nb; b++) begin
            @(posedge clk); #1;
            bus.rq_data_in[i*64 +: 64]  = d;
            bus.rq_last_len[i*LW +: LW] = 7'd64;
            bus.rq_in_valid[i]          = 1'b1;
            bus.rq_in_last[i]           = (b == nb - 1);
            st = mix(st, d, b == nb - 1, 7'd64);
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
                @(negedge clk);
                if (iso) iso_chk();
                ok = bus.rq_in_ready[i];
            end
            if (!ok) fail_now("absorb_wait");
        end
        @(posedge clk); #1;
        bus.rq_in_valid[i] = 1'b0;
        bus.rq_in_last[i]  = 1'b0;
    endtask

    task automatic squeeze(input int i, input int nw, input logic [63:0] st, input bit iso);
        int n;
        n = 0;
        for (int w = 0; w < nw; w++) dq.push_back(st ^ (64'(w + 1) * KSQZ));
        bus.rq_out_ready[i] = 1'b1;
        for (int c = 0; c < 40 && n < nw; c++) begin
            @(negedge clk);
            if (iso) iso_chk();
            if (bus.rq_out_valid[i]) n++;
        end
        @(posedge clk); #1;
        bus.rq_out_ready[i] = 1'b0;
        if (n < nw) fail_now("squeeze_wait");
    endtask

    task automatic txn(input int i, input int nb, input int nw, input logic [63:0] d,
                       input bit rereq, input bit iso);
        bit ok;
        logic [63:0] st;
        wait_gnt(i, ok);
        if (ok) begin
            absorb(i, nb, d, iso, st);
            squeeze(i, nw, st, iso);
        end
        bus.req[i] = 1'b0;
        if (rereq) begin
            @(posedge clk); #1;
            bus.req[i] = 1'b1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] st;
        bit ok;
        checks = 0; failures = 0;
        rst = 1'b0;
        bus.req = '0; bus.rq_data_in = '0; bus.rq_in_valid = '0; bus.rq_in_last = '0;
        bus.rq_out_ready = '0; bus.rq_last_len = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_owner", 64'(bus.owner), 64'd0);
        chk("rst_sp_clr", 64'(bus.sp_clr), 64'd1);
        chk("rst_sp_in_valid", 64'(bus.sp_in_valid), 64'd0);
        chk("rst_sp_out_ready", 64'(bus.sp_out_ready), 64'd0);
        chk("rst_rq_in_ready", 64'(bus.rq_in_ready), 64'd0);
        chk("rst_rq_out_valid", 64'(bus.rq_out_valid), 64'd0);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("idle_sp_clr", 64'(bus.sp_clr), 64'd0);

        // Single requester with grant latency
        gq.push_back(3'b001);
        @(posedge clk); #1; bus.req[0] = 1'b1;
        @(negedge clk);
        chk("lat0_gnt", 64'(bus.gnt), 64'd0);
        @(negedge clk);
        chk("lat1_gnt", 64'(bus.gnt), 64'd0);
        chk("lat1_clr", 64'(bus.sp_clr), 64'd1);
        chk("lat1_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("lat2_gnt", 64'(bus.gnt), 64'b001);
        absorb(0, 8, 64'h1234567890abcdef, 1'b0, st);
        squeeze(0, 4, st, 1'b0);
        bus.req[0] = 1'b0;

        // Contention from reset: 0, 1, 2
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        gq.push_back(3'b001); gq.push_back(3'b010); gq.push_back(3'b100);
        bus.req = 3'b111;
        for (int i = 0; i < NR; i++) txn(i, 2, 3, 64'hA5A5_0000_0000_0000 + 64'(i), 1'b0, 1'b0);

        // Fairness with requesters 0 and 1 held
        gq.push_back(3'b001); gq.push_back(3'b010); gq.push_back(3'b001); gq.push_back(3'b010);
        @(posedge clk); #1; bus.req[0] = 1'b1; bus.req[1] = 1'b1;
        txn(0, 1, 1, 64'h0F0F_0F0F_0000_0001, 1'b1, 1'b0);
        txn(1, 1, 1, 64'h0F0F_0F0F_0000_0002, 1'b1, 1'b0);
        txn(0, 1, 1, 64'h0F0F_0F0F_0000_0003, 1'b0, 1'b0);
        txn(1, 1, 1, 64'h0F0F_0F0F_0000_0004, 1'b0, 1'b0);

        // Isolation: requester 2 toggles valid while 1 owns the sponge
        gq.push_back(3'b010); gq.push_back(3'b100);
        @(posedge clk); #1; bus.req[1] = 1'b1;
        @(posedge clk); #1; bus.req[2] = 1'b1;
        txn(1, 2, 2, 64'hDEAD_BEEF_0000_0011, 1'b0, 1'b1);
        bus.rq_in_valid[2] = 1'b0;
        txn(2, 1, 1, 64'hDEAD_BEEF_0000_0022, 1'b0, 1'b0);

        // Abort during CLEAR keeps prio
        @(posedge clk); #1; bus.req[0] = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 64'(bus.busy), 64'd1);
        chk("abort_clr", 64'(bus.sp_clr), 64'd1);
        bus.req[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle_busy", 64'(bus.busy), 64'd0);
        chk("abort_idle_gnt", 64'(bus.gnt), 64'd0);
        gq.push_back(3'b001); gq.push_back(3'b010);
        bus.req[0] = 1'b1; bus.req[1] = 1'b1;
        txn(0, 1, 1, 64'h5555_0000_0000_0001, 1'b0, 1'b0);

        // Requester 1 drops req mid-absorb
        wait_gnt(1, ok);
        @(posedge clk); #1;
        bus.rq_data_in[64 +: 64]  = 64'h7777_0000_0000_0001;
        bus.rq_last_len[LW +: LW] = 7'd64;
        bus.rq_in_valid[1]        = 1'b1;
        #1 chk("drop_pre_sp_in_valid", 64'(bus.sp_in_valid), 64'd1);
        @(posedge clk); #1;
        bus.req[1] = 1'b0;
        #1;
        chk("drop_sp_in_valid", 64'(bus.sp_in_valid), 64'd0);
        chk("drop_rq_in_ready1", 64'(bus.rq_in_ready[1]), 64'd0);
        chk("drop_sp_data_in", bus.sp_data_in, 64'd0);
        @(posedge clk); #1;
        bus.rq_in_valid[1] = 1'b0;
        chk("drop_idle_busy", 64'(bus.busy), 64'd0);

        // Reset mid-GRANT
        gq.push_back(3'b001);
        bus.req[0] = 1'b1;
        wait_gnt(0, ok);
        absorb(0, 1, 64'h3333_0000_0000_0001, 1'b0, st);
        squeeze(0, 1, st, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstg_sp_clr", 64'(bus.sp_clr), 64'd1);
        chk("rstg_gnt_hold", 64'(bus.gnt), 64'b001);
        @(posedge clk); #1;
        rst = 1'b1; bus.req[0] = 1'b0;
        chk("rstg_gnt", 64'(bus.gnt), 64'd0);
        chk("rstg_busy", 64'(bus.busy), 64'd0);
        // prio back at 0: requester 1 beats 2
        gq.push_back(3'b010);
        @(posedge clk); #1; bus.req[1] = 1'b1; bus.req[2] = 1'b1;
        txn(1, 1, 1, 64'h4444_0000_0000_0001, 1'b0, 1'b0);
        bus.req[2] = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("gq_empty", 64'(gq.size()), 64'd0);
        chk("dq_empty", 64'(dq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shake_arbiter.md
# shake_arbiter

Round-robin arbiter that shares one SHAKE256 `sponge` instance between `NUM_REQ` requesters (SampleInBall, ExpandA, ExpandMask, …). It grants the sponge to one requester for a whole absorb/squeeze transaction and routes that requester's streaming handshake to the sponge. Between grants it clears the sponge so each transaction starts from a fresh Keccak state. It sits between the sampler blocks and the single shared `sponge`.

## Interface
- `NUM_REQ`, 3, number of requesters (2..8)
- `DATA_IN_BITS`, 64, sponge absorb width
- `DATA_OUT_BITS`, 64, sponge squeeze width
- `CLR_CYCLES`, 1, cycles `sp_clr` is held between grants (≥1)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-low; `rst=0` at a rising edge resets the block
- `req` in NUM_REQ: per-requester level request, held for the whole transaction
- `gnt` out NUM_REQ: one-hot grant, all zero when no owner
- `owner` out $clog2(NUM_REQ): index of current/last owner
- `busy` out 1: any state other than IDLE
- `rq_data_in` in NUM_REQ*DATA_IN_BITS: packed, requester i at [i*DATA_IN_BITS +: DATA_IN_BITS]
- `rq_in_valid`, `rq_in_last`, `rq_out_ready` in NUM_REQ each
- `rq_last_len` in NUM_REQ*($clog2(DATA_IN_BITS)+1): packed
- `rq_in_ready`, `rq_out_valid` out NUM_REQ: gated per requester
- `rq_data_out` out DATA_OUT_BITS: broadcast of `sp_data_out`
- `sp_clr` out 1: active-high clear, drives the sponge `rst`
- `sp_data_in` out DATA_IN_BITS; `sp_in_valid`, `sp_in_last`, `sp_out_ready` out 1; `sp_last_len` out $clog2(DATA_IN_BITS)+1
- `sp_data_out` in DATA_OUT_BITS; `sp_out_valid`, `sp_in_ready` in 1

## Operation
- States: IDLE, CLEAR, GRANT.
- IDLE:
  - If any `req` is set, latch the winner into `owner` and go to CLEAR.
  - Winner is the first set bit scanning upward from `prio` with wrap-around.
- CLEAR:
  - `sp_clr=1`. A down-counter counts CLR_CYCLES.
  - When the counter expires, go to GRANT.
  - If `req[owner]` drops during CLEAR, abandon and return to IDLE. `prio` is not updated.
- GRANT:
  - `gnt[owner]=1`.
  - If `req[owner]=0`, go to IDLE and set `prio=owner+1`, wrapping at NUM_REQ. The next winner then gets a fresh CLEAR.
- Routing when `gnt[i] & req[i]`:
  - `sp_*` outputs equal requester i's fields.
  - `rq_in_ready[i]=sp_in_ready` and `rq_out_valid[i]=sp_out_valid`.
- Routing otherwise: all `sp_*` outputs are 0, and all `rq_in_ready`/`rq_out_valid` are 0.
  - This gating is combinational on `req`. A requester dropping `req` is cut off in that same cycle; no sponge beat is accepted in that cycle.
- `sp_clr = ~rst | (state==CLEAR)`, so the sponge is reset together with the system.
- The arbiter never inspects sponge data or counts beats. Transaction length is defined solely by `req`.
- Requests from non-owners are ignored during CLEAR/GRANT. A non-owner's request waits; it is not queued beyond its level.

## Timing
- Reset values:
  - state=IDLE, `prio=0`, `owner=0`, `gnt=0`, `busy=0`.
  - `sp_clr=1` while `rst=0`.
  - All `sp_*` valid/ready outputs 0; `rq_in_ready=0`, `rq_out_valid=0`.
- Grant latency: `req` sampled high at edge t, then:
  - CLEAR for cycles t+1..t+CLR_CYCLES;
  - `gnt` high from t+CLR_CYCLES+1.
  - With default CLR_CYCLES=1, `gnt` rises 2 cycles after `req`.
- Release: `req[owner]` low sampled at edge t gives `gnt=0` and IDLE after t.
  - A pending requester then reaches CLEAR at t+1.
  - Minimum gap between grants is 1 IDLE cycle plus CLR_CYCLES.
- Simultaneous requests in IDLE resolve in the same cycle by rotation; exactly one `gnt` bit is ever set.
- `busy` is registered-state-derived. `gnt` and `owner` are decoded from registered state, not from `req`.
- Reset asserted mid-GRANT takes effect at the next edge:
  - `gnt` drops and `sp_clr` is high immediately (combinational on `rst`).
  - The requester must restart its transaction.
- Handshake semantics (valid/ready, `in_last`/`last_len`) pass through unchanged, with zero added latency.

## Test plan
- Single requester: `req[0]` high, absorb 8 beats of `0x1234567890abcdef` with the last beat `last_len=64`, squeeze 4 words. `gnt=001` 2 cycles after `req`; the `rq_data_out` words equal a stand-alone sponge run on the same input.
- Contention: `req=111` asserted in the same cycle from reset.
  - Grants go 0, then 1, then 2, each released after 3 squeeze beats.
  - `gnt` is never multi-hot, and each grant is preceded by exactly 1 `sp_clr` cycle.
- Fairness: `req[0]` and `req[1]` held continuously with short transactions. Grants alternate 0, 1, 0, 1, and `req[0]` never wins twice in a row.
- Isolation: while requester 1 owns the sponge, requester 2 toggles `rq_in_valid`. `sp_in_valid` follows only requester 1, and `rq_in_ready[2]=0` and `rq_out_valid[2]=0` throughout.
- Abort/release edge:
  - Requester 0 drops `req` during CLEAR: back to IDLE, `prio` unchanged, and requester 0 is re-granted on re-request.
  - Requester 1 drops `req` mid-absorb: `sp_in_valid=0` in the same cycle.
- Reset mid-GRANT: drive `rst=0` for 1 cycle during the squeeze. `gnt=0`, `busy=0` and `prio=0` after the edge, and `sp_clr=1` during that cycle.
